bcd_serial_subtractor: RTL

//  Digit-serial packed-BCD subtractor; the subtract counterpart of the team's BCD adder datapath.

---
 rtl/bcd_serial_subtractor.sv | 131 +++++++++++++
 1 files changed

// File: rtl/bcd_serial_subtractor.sv
// Digit-serial packed-BCD subtractor: |a - b| one digit per clock, LSD first,
// followed by a ten's-complement pass over the result when a < b.
module bcd_serial_subtractor #(
    parameter int N_DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*N_DIGITS-1:0] a,
    input  logic [4*N_DIGITS-1:0] b,
    output logic [4*N_DIGITS-1:0] diff,
    output logic                  neg,
    output logic                  err,
    output logic                  busy,
    output logic                  done
);
    localparam int W  = 4 * N_DIGITS;
    localparam int CW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, SUB, NEG, DONE} state_t;

    state_t          r_state, w_state_nxt;
    logic [W-1:0]    r_a, r_b, r_diff;
    logic [CW-1:0]   r_cnt;
    logic            r_borrow, r_neg, r_err, r_busy, r_done;

    logic [3:0]      w_a_dig, w_b_dig, w_d_dig, w_op_a, w_op_b, w_res;
    logic            w_bad, w_borrow_nxt, w_last;
    logic [4:0]      w_sub;

    // Returns {borrow_out, digit} for x - y - bin with the +10 correction.
    function automatic logic [4:0] sub_digit(input logic [3:0] x, input logic [3:0] y,
                                             input logic bin);
        logic signed [5:0] t;
        t = $signed({2'b00, x}) - $signed({2'b00, y}) - $signed({5'b00000, bin});
        if (t < 0)
            sub_digit = {1'b1, 4'(t + 6'sd10)};
        else
            sub_digit = {1'b0, t[3:0]};
    endfunction

    assign w_a_dig = r_a[4*r_cnt +: 4];
    assign w_b_dig = r_b[4*r_cnt +: 4];
    assign w_d_dig = r_diff[4*r_cnt +: 4];
    assign w_last  = (r_cnt == CW'(N_DIGITS - 1));

    // The NEG pass reuses the digit subtractor as 0 - diff_i - borrow.
    assign w_op_a  = (r_state == NEG) ? 4'd0 : w_a_dig;
    assign w_op_b  = (r_state == NEG) ? w_d_dig : w_b_dig;
    assign w_bad   = (r_state == SUB) && ((w_a_dig > 4'd9) || (w_b_dig > 4'd9));
    assign w_sub   = sub_digit(w_op_a, w_op_b, r_borrow);

    always_comb begin
        w_res        = w_sub[3:0];
        w_borrow_nxt = w_sub[4];
        if (w_bad) begin
            w_res        = 4'd0;
            w_borrow_nxt = 1'b0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (start) w_state_nxt = SUB;
            SUB:  if (w_last) w_state_nxt = w_borrow_nxt ? NEG : DONE;
            NEG:  if (w_last) w_state_nxt = DONE;
            DONE: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (r_state == IDLE && start) begin
            r_a <= a;
            r_b <= b;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_diff   <= '0;
            r_neg    <= 1'b0;
            r_err    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_cnt    <= '0;
            r_borrow <= 1'b0;
        end else begin
            r_done <= (w_state_nxt == DONE);
            r_busy <= (w_state_nxt != IDLE);
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_cnt    <= '0;
                        r_borrow <= 1'b0;
                        r_err    <= 1'b0;
                        r_neg    <= 1'b0;
                        r_diff   <= '0;
                    end
                end
                SUB, NEG: begin
                    r_diff[4*r_cnt +: 4] <= w_res;
                    if (w_bad) r_err <= 1'b1;
                    if (w_last) begin
                        r_cnt    <= '0;
                        r_borrow <= 1'b0;
                        if (r_state == SUB && w_borrow_nxt) r_neg <= 1'b1;
                    end else begin
                        r_cnt    <= r_cnt + 1'b1;
                        r_borrow <= w_borrow_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign diff = r_diff;
    assign neg  = r_neg;
    assign err  = r_err;
    assign busy = r_busy;
    assign done = r_done;
endmodule
